// File: rtl/io_input_conditioner.sv
// Switch/confirm-button conditioner: 2-FF sync, tick-sampled debounce,
// confirm-triggered capture of the switch word with sticky ready/overrun flags.
module io_input_conditioner #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DB_CNT = 1_000_000,
  parameter int unsigned CNT_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             btn_raw,
  input  logic             ack,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] latched_word,
  output logic             btn_pulse,
  output logic             data_ready,
  output logic             overrun
);

  localparam int unsigned N = WIDTH + 1;

  typedef enum logic {
    SETTLED   = 1'b0,
    CANDIDATE = 1'b1
  } db_state_e;

  logic [N-1:0]     raw_in;
  logic [N-1:0]     s1_q, s1_d, s2_q, s2_d;
  logic [N-1:0]     stable_q, stable_d;
  db_state_e        state_q [N];
  db_state_e        state_d [N];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             btn_pulse_q, btn_pulse_d;
  logic [WIDTH-1:0] latched_q, latched_d;
  logic             ready_q, ready_d;
  logic             over_q, over_d;

  assign raw_in = {btn_raw, sw_raw};
  assign tick   = (cnt_q == CNT_W'(DB_CNT - 1));

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    s1_d     = raw_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    state_d  = state_q;
    // The previous tick sample is not stored: CANDIDATE means it differed
    // from the stable level, SETTLED means it matched.
    if (tick) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (s2_q[i] == (stable_q[i] ^ (state_q[i] == CANDIDATE))) begin
          stable_d[i] = s2_q[i];
          state_d[i]  = SETTLED;
        end else begin
          state_d[i]  = (s2_q[i] != stable_q[i]) ? CANDIDATE : SETTLED;
        end
      end
    end

    btn_pulse_d = stable_d[WIDTH] & ~stable_q[WIDTH];

    latched_d = latched_q;
    ready_d   = ready_q;
    over_d    = over_q;
    if (btn_pulse_q) begin
      latched_d = stable_q[WIDTH-1:0];
      ready_d   = 1'b1;
      over_d    = ack ? 1'b0 : (over_q | ready_q);
    end else if (ack) begin
      ready_d = 1'b0;
      over_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      stable_q    <= '0;
      cnt_q       <= '0;
      btn_pulse_q <= 1'b0;
      latched_q   <= '0;
      ready_q     <= 1'b0;
      over_q      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) state_q[i] <= SETTLED;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      btn_pulse_q <= btn_pulse_d;
      latched_q   <= latched_d;
      ready_q     <= ready_d;
      over_q      <= over_d;
      state_q     <= state_d;
    end
  end

  assign sw_stable    = stable_q[WIDTH-1:0];
  assign latched_word = latched_q;
  assign btn_pulse    = btn_pulse_q;
  assign data_ready   = ready_q;
  assign overrun      = over_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner: a behavioural model predicts the
// outputs after every clock edge; a monitor compares them one cycle at a time.
module tb_io_input_conditioner;

  localparam int DB = 4;

  logic        clk;
  logic        rst;
  logic [15:0] sw_raw;
  logic        btn_raw;
  logic        ack;
  logic [15:0] sw_stable;
  logic [15:0] latched_word;
  logic        btn_pulse;
  logic        data_ready;
  logic        overrun;

  io_input_conditioner #(.WIDTH(16), .DB_CNT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw), .ack(ack),
    .sw_stable(sw_stable), .latched_word(latched_word), .btn_pulse(btn_pulse),
    .data_ready(data_ready), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sw;
    logic [15:0] lw;
    logic        p;
    logic        r;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Model state, in the specification's own terms.
  logic [16:0] m_s1, m_s2, m_prev, m_stable;
  int          m_edges;
  logic        m_pulse, m_ready, m_over;
  logic [15:0] m_latched;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge and predict the state
  // that the following rising edge will produce.
  task automatic cyc(input logic r, input logic [15:0] w, input logic b, input logic a);
    logic [16:0] eq, n_stable;
    logic        n_pulse, n_ready, n_over;
    logic [15:0] n_latched;
    exp_t        e;
    @(negedge clk);
    rst = r; sw_raw = w; btn_raw = b; ack = a;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_prev = '0; m_stable = '0; m_edges = 0;
      m_pulse = 1'b0; m_ready = 1'b0; m_over = 1'b0; m_latched = '0;
    end else begin
      n_stable = m_stable;
      if (m_edges % DB == DB - 1) begin
        eq       = ~(m_s2 ^ m_prev);
        n_stable = (m_stable & ~eq) | (m_s2 & eq);
        m_prev   = m_s2;
      end
      n_pulse   = n_stable[16] & ~m_stable[16];
      n_latched = m_latched;
      n_ready   = m_ready;
      n_over    = m_over;
      if (m_pulse) begin
        n_latched = m_stable[15:0];
        n_ready   = 1'b1;
        n_over    = a ? 1'b0 : (m_ready | m_over);
      end else if (a) begin
        n_ready = 1'b0;
        n_over  = 1'b0;
      end
      m_stable = n_stable; m_pulse = n_pulse; m_latched = n_latched;
      m_ready = n_ready; m_over = n_over;
      m_s2 = m_s1; m_s1 = {b, w};
      m_edges++;
    end
    e.sw = m_stable[15:0]; e.lw = m_latched; e.p = m_pulse; e.r = m_ready; e.o = m_over;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sw_stable",    {16'h0, sw_stable},    {16'h0, e.sw});
        check("latched_word", {16'h0, latched_word}, {16'h0, e.lw});
        check("btn_pulse",    {31'h0, btn_pulse},    {31'h0, e.p});
        check("data_ready",   {31'h0, data_ready},   {31'h0, e.r});
        check("overrun",      {31'h0, overrun},      {31'h0, e.o});
      end
    end
  end

  int npulse;

  // Settle the word, hold the button 20 cycles, release and settle again.
  task automatic press(input logic [15:0] w, input bit ack_on_pulse);
    npulse = 0;
    repeat (12) cyc(1'b0, w, 1'b0, 1'b0);
    repeat (20) begin
      cyc(1'b0, w, 1'b1, ack_on_pulse ? m_pulse : 1'b0);
      if (btn_pulse === 1'b1) npulse++;
    end
    repeat (12) begin
      cyc(1'b0, w, 1'b0, 1'b0);
      if (btn_pulse === 1'b1) npulse++;
    end
  endtask

  initial begin
    int          n;
    logic [15:0] w;
    logic        b;
    rst = 1'b1; sw_raw = '0; btn_raw = 1'b0; ack = 1'b0;

    // Reset with all inputs high.
    repeat (3) cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (12) cyc(1'b0, 16'h0000, 1'b0, 1'b0);

    // Glitch on bit 0 for two cycles.
    repeat (2) cyc(1'b0, 16'h0001, 1'b0, 1'b0);
    repeat (12) begin
      cyc(1'b0, 16'h0000, 1'b0, 1'b0);
      check("glitch_bit0", {31'h0, sw_stable[0]}, 32'h0);
    end

    // Debounce acceptance latency.
    n = 0;
    while (sw_stable !== 16'hA5A5 && n < 14) begin
      cyc(1'b0, 16'hA5A5, 1'b0, 1'b0);
      n++;
    end
    check("accept_value", {16'h0, sw_stable}, 32'h0000A5A5);
    check("accept_not_early", {31'h0, n >= 8}, 32'h1);
    check("accept_not_late", {31'h0, n <= 11}, 32'h1);

    // Capture and acknowledge.
    press(16'h1234, 1'b0);
    check("capture_pulses", npulse, 32'd1);
    check("capture_word", {16'h0, latched_word}, 32'h00001234);
    check("capture_ready", {31'h0, data_ready}, 32'h1);
    cyc(1'b0, 16'h1234, 1'b0, 1'b1);
    cyc(1'b0, 16'h1234, 1'b0, 1'b0);
    check("ack_ready", {31'h0, data_ready}, 32'h0);
    check("ack_word", {16'h0, latched_word}, 32'h00001234);

    // Overrun.
    press(16'h0001, 1'b0);
    press(16'h0002, 1'b0);
    check("ovr_word", {16'h0, latched_word}, 32'h00000002);
    check("ovr_ready", {31'h0, data_ready}, 32'h1);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    cyc(1'b0, 16'h0002, 1'b0, 1'b1);
    cyc(1'b0, 16'h0002, 1'b0, 1'b0);
    check("ovr_ack_ready", {31'h0, data_ready}, 32'h0);
    check("ovr_ack_flag", {31'h0, overrun}, 32'h0);

    // Collision of ack with a capture while overrun is pending.
    press(16'hBEEF, 1'b0);
    press(16'hCAFE, 1'b0);
    check("pre_coll_ovr", {31'h0, overrun}, 32'h1);
    press(16'h0C0C, 1'b1);
    check("coll_word", {16'h0, latched_word}, 32'h00000C0C);
    check("coll_ready", {31'h0, data_ready}, 32'h1);
    check("coll_ovr", {31'h0, overrun}, 32'h0);

    // Randomised traffic, including occasional resets.
    w = 16'h0; b = 1'b0;
    repeat (600) begin
      if ($urandom_range(0, 9) == 0) w = 16'($urandom);
      else if ($urandom_range(0, 5) == 0) w = w ^ (16'h1 << $urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) b = ~b;
      cyc($urandom_range(0, 249) == 0, w, b, $urandom_range(0, 7) == 0);
    end

    @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
